hpb_wr_arbiter: RTL
===================

// Module: hpb_wr_arbiter
// PURPOSE
//  Shares the single HPB write port into the RCB RAM between NUM_REQ requesters (host config, strategy update, ...).
//  Round-robin arbitration; one write in flight at a time, held until rcb_wr_done or timeout.
//  Sits between the requester blocks and the hpb_if signal group that drives the RCB RAM writer.
// PARAMETERS
//  NUM_REQ             2    number of requesters (>=2)
//  RCB_RAM_ADDR_WIDTH  14   write address width
//  RCB_RAM_WIDTH       64   write data width; byte-enable width = RCB_RAM_WIDTH/8
//  TIMEOUT_CYCLES      256  max BUSY cycles awaiting rcb_wr_done; 0 disables timeout
// PORTS
//  clk              in   1                      clock; single clock domain
//  reset_n          in   1                      synchronous, active-low reset
//  req_valid        in   NUM_REQ                per-requester write request; fields stable while high and not acked
//  req_addr         in   NUM_REQ*ADDR_W         flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_data         in   NUM_REQ*RCB_RAM_WIDTH  flattened write data
//  req_byte_en      in   NUM_REQ*RCB_RAM_WIDTH/8  flattened byte enables
//  req_ack          out  NUM_REQ                1-cycle pulse: request captured; requester may drop or change fields
//  req_done         out  NUM_REQ                1-cycle pulse: captured write completed
//  req_err          out  NUM_REQ                1-cycle pulse: captured write aborted by timeout
//  hpb_wr_addr      out  ADDR_W                 RCB RAM write address
//  hpb_wr_data      out  RCB_RAM_WIDTH          RCB RAM write data
//  hpb_wr_byte_en   out  RCB_RAM_WIDTH/8        RCB RAM byte enables
//  hpb_wr_req       out  1                      write request, level, held until done/timeout
//  rcb_wr_done      in   1                      1-cycle completion from RCB RAM side
//  busy             out  1                      high in BUSY state
//  grant_id         out  $clog2(NUM_REQ)        index of current/last granted requester
//  err_clr          in   1                      clears sticky error flags
//  err_timeout      out  1                      sticky: a timeout occurred
//  err_spurious     out  1                      sticky: rcb_wr_done seen while not BUSY
// BEHAVIOUR
//  Reset (reset_n low at clk edge): state IDLE; every output 0 (hpb_* buses, req_ack/done/err, busy, grant_id, sticky flags).
//   rr pointer = NUM_REQ-1, so requester 0 has top priority first. Reset mid-write drops hpb_wr_req next cycle; no done/err pulse.
//  FSM states: IDLE, BUSY. All outputs registered.
//  IDLE: if any req_valid, winner = first valid index searching from rr+1 upward, wrapping modulo NUM_REQ.
//   On that edge: latch winner's addr/data/byte_en onto hpb_wr_*, hpb_wr_req<=1, req_ack[winner]<=1,
//   grant_id<=winner, rr<=winner, timeout counter<=0, go BUSY.
//   Latency: req_valid sampled in cycle C -> hpb_wr_req and req_ack high in C+1.
//  BUSY: hpb_wr_* stable; req_valid ignored (requesters may queue the next request after ack).
//   rcb_wr_done=1 in cycle N -> N+1: hpb_wr_req=0, req_done[grant_id]=1, state IDLE.
//   Else counter increments; counter==TIMEOUT_CYCLES-1 without done -> next cycle: hpb_wr_req=0,
//   req_err[grant_id]=1, err_timeout<=1, IDLE. Done and timeout in the same cycle: done wins.
//  Successive writes are separated by >=1 cycle with hpb_wr_req low (the IDLE cycle where done/err is pulsed).
//   New request may be sampled in that IDLE cycle.
//  hpb_wr_addr/data/byte_en hold their last values when idle (not zeroed).
//  rcb_wr_done while IDLE: ignored functionally, err_spurious<=1.
//  err_clr: clears sticky flags; a same-cycle set wins over clear.
//  req_ack/done/err: at most one bit set per vector, each exactly one cycle wide.
//  Counter width $clog2(TIMEOUT_CYCLES+1); no wrap (saturates at compare).
// TESTING
//  Single: reset, req_valid[0]=1 addr=0x0010 data=0xDEADBEEF_01234567 be=0xFF -> next cycle hpb_wr_req=1, ack[0]; done 3 cycles later -> req_done[0] next cycle, req low.
//  Contention: req_valid=2'b11 held, done 2 cycles after each req -> grants alternate 0,1,0,1; each ack exactly once per capture.
//  Timeout: TIMEOUT_CYCLES=8, never assert done -> hpb_wr_req high 8 cycles then low, req_err[grant]=1, err_timeout=1 until err_clr.
//  Done on timeout cycle: done at cycle 8 of BUSY -> req_done pulse, no req_err, err_timeout stays 0.
//  Spurious/reset: rcb_wr_done in IDLE -> err_spurious=1, no done pulse; reset_n low mid-BUSY -> all outputs 0 next cycle, grant restarts at 0.
//  Back-to-back: requester re-asserts valid right after ack -> new write starts 1 cycle after prior req_done, bus fields change only at that edge.

Source files
------------

// File: rtl/hpb_wr_arbiter_if.sv
// HPB write port signal group between the arbiter and the RCB RAM writer.
// The arbiter drives the write bus; the RAM side returns the completion.
interface hpb_wr_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0]   hpb_wr_addr;
    logic [DATA_W-1:0]   hpb_wr_data;
    logic [DATA_W/8-1:0] hpb_wr_byte_en;
    logic                hpb_wr_req;
    logic                rcb_wr_done;

    modport master (
        output hpb_wr_addr,
        output hpb_wr_data,
        output hpb_wr_byte_en,
        output hpb_wr_req,
        input  rcb_wr_done
    );

    modport slave (
        input  hpb_wr_addr,
        input  hpb_wr_data,
        input  hpb_wr_byte_en,
        input  hpb_wr_req,
        output rcb_wr_done
    );
endinterface

// File: rtl/hpb_wr_arbiter.sv
// Round-robin arbiter sharing the single HPB write port into RCB RAM.
// One write in flight; held until rcb_wr_done or the BUSY timeout.
module hpb_wr_arbiter #(
    parameter int NUM_REQ            = 2,
    parameter int RCB_RAM_ADDR_WIDTH = 14,
    parameter int RCB_RAM_WIDTH      = 64,
    parameter int TIMEOUT_CYCLES     = 256
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ*RCB_RAM_ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*RCB_RAM_WIDTH-1:0]      req_data,
    input  logic [NUM_REQ*(RCB_RAM_WIDTH/8)-1:0]  req_byte_en,
    output logic [NUM_REQ-1:0]                    req_ack,
    output logic [NUM_REQ-1:0]                    req_done,
    output logic [NUM_REQ-1:0]                    req_err,
    hpb_wr_arbiter_if.master                      hpb,
    output logic                                  busy,
    output logic [$clog2(NUM_REQ)-1:0]            grant_id,
    input  logic                                  err_clr,
    output logic                                  err_timeout,
    output logic                                  err_spurious
);
    localparam int AW  = RCB_RAM_ADDR_WIDTH;
    localparam int DW  = RCB_RAM_WIDTH;
    localparam int BW  = RCB_RAM_WIDTH / 8;
    localparam int IDW = $clog2(NUM_REQ);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int CW  = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    data_q, data_d;
    logic [BW-1:0]    be_q, be_d;
    logic             wr_req_q, wr_req_d;
    logic             busy_q, busy_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic             to_q, to_d;
    logic             sp_q, sp_d;

    logic [IDW-1:0]   win;
    logic             win_found;
    logic             to_hit;
    logic             to_set;
    logic             sp_set;

    assign to_hit = TO_EN && (cnt_q == CNT_LAST);

    // Pick the first valid requester after the last winner, wrapping.
    always_comb begin
        win       = rr_q;
        win_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found &&
                req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
                win       = IDW'((int'(rr_q) + k) % NUM_REQ);
                win_found = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: grant when idle, release on done or timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req_valid) state_d = S_BUSY;
            end
            S_BUSY: begin
                if (hpb.rcb_wr_done || to_hit) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; done beats a same-cycle timeout.
    always_comb begin
        rr_d     = rr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        be_d     = be_q;
        wr_req_d = wr_req_q;
        ack_d    = '0;
        done_d   = '0;
        err_d    = '0;
        to_set   = 1'b0;
        sp_set   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                sp_set = hpb.rcb_wr_done;
                if (|req_valid) begin
                    addr_d     = req_addr[int'(win)*AW +: AW];
                    data_d     = req_data[int'(win)*DW +: DW];
                    be_d       = req_byte_en[int'(win)*BW +: BW];
                    wr_req_d   = 1'b1;
                    ack_d[win] = 1'b1;
                    grant_d    = win;
                    rr_d       = win;
                    cnt_d      = '0;
                end
            end
            S_BUSY: begin
                if (hpb.rcb_wr_done) begin
                    wr_req_d        = 1'b0;
                    done_d[grant_q] = 1'b1;
                end else if (to_hit) begin
                    wr_req_d       = 1'b0;
                    err_d[grant_q] = 1'b1;
                    to_set         = 1'b1;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        busy_d = (state_d == S_BUSY);
        to_d   = to_set | (to_q & ~err_clr);
        sp_d   = sp_set | (sp_q & ~err_clr);
    end

    // Output and datapath registers; reset clears every output.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_q     <= IDW'(NUM_REQ - 1);
            grant_q  <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            be_q     <= '0;
            wr_req_q <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            to_q     <= 1'b0;
            sp_q     <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            be_q     <= be_d;
            wr_req_q <= wr_req_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            err_q    <= err_d;
            to_q     <= to_d;
            sp_q     <= sp_d;
        end
    end

    assign hpb.hpb_wr_addr    = addr_q;
    assign hpb.hpb_wr_data    = data_q;
    assign hpb.hpb_wr_byte_en = be_q;
    assign hpb.hpb_wr_req     = wr_req_q;
    assign req_ack            = ack_q;
    assign req_done           = done_q;
    assign req_err            = err_q;
    assign busy               = busy_q;
    assign grant_id           = grant_q;
    assign err_timeout        = to_q;
    assign err_spurious       = sp_q;
endmodule
